cci_write_staging_buffer: RTL and testbench
===========================================

// Module: cci_write_staging_buffer
// PURPOSE
//  Staging FIFO between the frame writer and the CCI tx1 write arbiter. Accepts write
//  packets (tx header + 512b line) on a valid/ready port and presents them as a write
//  request to the arbiter, popping on write_grant. Counts writes in flight against rx1
//  write responses and withholds requests once MAX_OUTSTANDING writes are unacknowledged.
// PARAMETERS
//  DEPTH            8   FIFO entries; power of 2, >= 2
//  MAX_OUTSTANDING  32  max granted-but-unacknowledged writes; 1..255
// PORTS
//  clk           in   1    clock; single domain
//  resetb        in   1    reset: synchronous, active-high (asserted = 1)
//  afu_en        in   1    AFU enable from CSR block; low = flush
//  in_valid      in   1    producer has a write packet
//  in_ready      out  1    buffer accepts packet this cycle
//  in_header     in   hdr  tx_header_t write header
//  in_data       in   512  cache-line payload
//  wr_request    out  1    to arbiter: head entry eligible to issue
//  wr_header     out  hdr  head entry header
//  wr_data       out  512  head entry data
//  write_grant   in   1    from arbiter: head entry taken this cycle
//  wr_rsp_valid  in   1    rx1 write response: one write completed
//  outstanding   out  8    writes granted, not yet acknowledged
//  idle          out  1    FIFO empty and outstanding == 0
//  error         out  1    sticky protocol error
// BEHAVIOUR
//  - Reset (resetb=1 at clk edge): FIFO empty, outstanding=0, error=0; while asserted
//    in_ready=0, wr_request=0, idle=1. Reset mid-packet drops all FIFO contents.
//  - Push when in_valid && in_ready. in_ready = !full && afu_en && !resetb. No bypass:
//    with FIFO full, a same-cycle pop does not permit a push (in_ready stays 0).
//  - First-word fall-through: wr_header/wr_data are the head entry, combinational from
//    storage; a packet pushed at edge N is requestable in cycle N+1 (1-cycle latency).
//  - wr_request = !empty && afu_en && (outstanding < MAX_OUTSTANDING); combinational.
//  - write_grant is combinational from the arbiter in the same cycle as wr_request; the
//    head pops at that clk edge. Next entry presented in the following cycle; back-to-back
//    grants drain one entry per cycle.
//  - write_grant while wr_request=0: ignored (no pop, no count change), error <= 1.
//  - outstanding: +1 on accepted grant, -1 on wr_rsp_valid; both in the same cycle ->
//    unchanged. wr_rsp_valid with outstanding==0: counter holds 0, error <= 1.
//  - At outstanding == MAX_OUTSTANDING, wr_request drops in the same cycle the count is
//    reached and reasserts the cycle after a response lowers it.
//  - afu_en low: FIFO flushed at next edge (pointers cleared), in_ready=0, wr_request=0;
//    outstanding keeps counting responses so late completions drain; error not cleared.
//  - Full/empty: pointers are log2(DEPTH)+1 bits; full = MSBs differ and indices equal;
//    empty = pointers equal. Pointer wrap is natural modulo 2*DEPTH.
//  - error is cleared only by reset.
// STRUCTURE
//  - Shared package qpi_pkg: tx_header_t, CCI_DATA_W=512, CCI_OUTSTANDING_W=8.
//  - Sub-module cci_sync_fifo #(WIDTH, DEPTH): FWFT storage, push/pop, full/empty.
//    This block adds request gating, the outstanding counter, flush and error logic.
// TESTING
//  1 Reset, then push 3 packets (hdr addr 0x10,0x11,0x12), grant every cycle -> wr_header
//    addr 0x10,0x11,0x12 on consecutive cycles; outstanding=3; idle=0.
//  2 DEPTH=8, no grants, in_valid held for 10 cycles -> exactly 8 accepted, in_ready=0
//    from the cycle after the 8th push; full + same-cycle pop still shows in_ready=0.
//  3 MAX_OUTSTANDING=4, 6 queued, continuous grants, no responses -> 4 grants, then
//    wr_request=0; one wr_rsp_valid -> wr_request=1 next cycle, 5th packet issues.
//  4 Grant and wr_rsp_valid in the same cycle at outstanding=2 -> outstanding stays 2.
//  5 wr_rsp_valid at outstanding=0 -> error=1, outstanding=0; stray grant with empty
//    FIFO -> error=1, no pointer change.
//  6 afu_en low with 5 queued and outstanding=3 -> FIFO empty next cycle, wr_request=0;
//    3 responses -> outstanding=0, idle=1.

Source files
------------

// File: rtl/qpi_pkg.sv
// Shared CCI/QPI types for the write path: tx header layout, line width,
// and the width of the write-outstanding counter.
// Pure type/constant package; no logic, no latency, no backpressure.
package qpi_pkg;

  localparam int CCI_DATA_W        = 512;
  localparam int CCI_OUTSTANDING_W = 8;

  typedef enum logic [3:0] {
    REQ_WRLINE_I = 4'h1,
    REQ_WRLINE_M = 4'h2,
    REQ_WRFENCE  = 4'h5
  } tx_req_t;

  typedef struct packed {
    logic [5:0]  rsvd;
    tx_req_t     req_type;
    logic [1:0]  vc;
    logic [15:0] mdata;
    logic [41:0] addr;
  } tx_header_t;

  localparam int TX_HDR_W = $bits(tx_header_t);

endpackage

// File: rtl/cci_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous clear.
// Latency: a push at edge N is visible on o_dat in cycle N+1.
// Backpressure: caller must not push when o_full nor pop when o_empty.
//
// Ports: clk; i_clear (drops all entries at next edge, wins over push/pop);
//        i_push/i_dat write side; i_pop/o_dat read side; o_full/o_empty status.
module cci_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

  assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/cci_write_staging_buffer.sv
// Stages frame-writer packets for the CCI tx1 arbiter, gates requests on outstanding writes.
// Latency: 1 cycle push-to-request (FWFT head); head pops at the edge of a granted cycle.
// Backpressure: in_ready low when full, disabled or in reset; no full-FIFO push/pop bypass.
//
// Ports: clk/resetb (sync, active-high); afu_en (low flushes FIFO);
//        in_valid/in_ready/in_header/in_data producer side;
//        wr_request/wr_header/wr_data/write_grant arbiter side; wr_rsp_valid rx1 completion;
//        outstanding (granted, unacknowledged), idle, sticky error.
module cci_write_staging_buffer
  import qpi_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic                         afu_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  tx_header_t                   in_header,
  input  logic [CCI_DATA_W-1:0]        in_data,
  output logic                         wr_request,
  output tx_header_t                   wr_header,
  output logic [CCI_DATA_W-1:0]        wr_data,
  input  logic                         write_grant,
  input  logic                         wr_rsp_valid,
  output logic [CCI_OUTSTANDING_W-1:0] outstanding,
  output logic                         idle,
  output logic                         error
);

  localparam int ENTRY_W = TX_HDR_W + CCI_DATA_W;
  localparam logic [CCI_OUTSTANDING_W-1:0] LP_MAX_OUT = CCI_OUTSTANDING_W'(MAX_OUTSTANDING);

  logic                         w_full;
  logic                         w_empty;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_clear;
  logic                         w_stray_grant;
  logic                         w_rsp_underflow;
  logic [ENTRY_W-1:0]           w_head;
  logic [CCI_OUTSTANDING_W-1:0] w_out_nxt;
  logic [CCI_OUTSTANDING_W-1:0] r_outstanding;
  logic                         r_error;

  // Reset and disable both drop queued packets; neither touches outstanding
  // except reset, so late completions after a disable still drain the count.
  assign w_clear = resetb || !afu_en;

  cci_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_dat   ({in_header, in_data}),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready   = !w_full && afu_en && !resetb;
  // Gating on the registered count makes the request drop in the same cycle
  // the limit is reached and come back the cycle after a response.
  assign wr_request = !w_empty && afu_en && !resetb && (r_outstanding < LP_MAX_OUT);

  assign w_push        = in_valid && in_ready;
  assign w_pop         = write_grant && wr_request;
  assign w_stray_grant = write_grant && !wr_request;

  assign {wr_header, wr_data} = w_head;

  // Grant and response in one cycle cancel; a lone response at zero is a
  // protocol violation and leaves the counter at zero.
  always_comb begin
    w_out_nxt       = r_outstanding;
    w_rsp_underflow = 1'b0;
    unique case ({w_pop, wr_rsp_valid})
      2'b10: w_out_nxt = r_outstanding + 1'b1;
      2'b01: begin
        if (r_outstanding == '0) w_rsp_underflow = 1'b1;
        else                     w_out_nxt       = r_outstanding - 1'b1;
      end
      default: w_out_nxt = r_outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      r_outstanding <= '0;
      r_error       <= 1'b0;
    end else begin
      r_outstanding <= w_out_nxt;
      r_error       <= r_error | w_stray_grant | w_rsp_underflow;
    end
  end

  assign outstanding = r_outstanding;
  assign error       = r_error;
  assign idle        = resetb || (w_empty && (r_outstanding == '0));

endmodule

// File: tb/tb_cci_write_staging_buffer.sv
module tb_cci_write_staging_buffer;
  import qpi_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXO  = 4;

  typedef struct packed {
    tx_header_t             h;
    logic [CCI_DATA_W-1:0]  d;
  } pkt_t;

  logic                         clk = 1'b0;
  logic                         resetb;
  logic                         afu_en;
  logic                         in_valid;
  logic                         in_ready;
  tx_header_t                   in_header;
  logic [CCI_DATA_W-1:0]        in_data;
  logic                         wr_request;
  tx_header_t                   wr_header;
  logic [CCI_DATA_W-1:0]        wr_data;
  logic                         write_grant;
  logic                         wr_rsp_valid;
  logic [CCI_OUTSTANDING_W-1:0] outstanding;
  logic                         idle;
  logic                         error;

  cci_write_staging_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .resetb(resetb), .afu_en(afu_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_header(in_header), .in_data(in_data), .wr_request(wr_request), .wr_header(wr_header),
    .wr_data(wr_data), .write_grant(write_grant), .wr_rsp_valid(wr_rsp_valid),
    .outstanding(outstanding), .idle(idle), .error(error)
  );

  always #5 clk = ~clk;

  // Reference model: queue of packets, integer outstanding count, sticky error.
  pkt_t   m_q[$];
  int     m_out;
  bit     m_err;

  // Bench-side arbiter controls
  bit     grant_req;
  bit     stray;

  int     n_vec;
  int     n_bad;
  int     n_gnt;
  int     n_acc;
  logic [41:0] gnt_log[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy();
    return !resetb && afu_en && (m_q.size() < DEPTH);
  endfunction

  function automatic bit m_req();
    return !resetb && afu_en && (m_q.size() > 0) && (m_out < MAXO);
  endfunction

  task automatic new_pkt(input logic [41:0] addr);
    tx_header_t h;
    h          = '0;
    h.req_type = REQ_WRLINE_I;
    h.mdata    = 16'($urandom());
    h.addr     = addr;
    in_header  = h;
    for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = $urandom();
  endtask

  // One clock: inputs already driven at the preceding negedge.
  task automatic step();
    bit e_push, e_pop, e_req;
    #1;
    e_req       = m_req();
    write_grant = stray || (grant_req && e_req);
    #1;
    chk("in_ready",    in_ready,    m_rdy());
    chk("wr_request",  wr_request,  e_req);
    chk("outstanding", outstanding, m_out);
    chk("idle",        idle,        resetb || (m_q.size() == 0 && m_out == 0));
    chk("error",       error,       m_err);
    if (e_req) begin
      chk("wr_header", wr_header, m_q[0].h);
      chk("wr_data",   wr_data,   m_q[0].d);
    end
    if (write_grant && wr_request) begin
      n_gnt++;
      gnt_log.push_back(wr_header.addr);
    end
    if (in_valid && in_ready) n_acc++;
    e_push = in_valid && m_rdy();
    e_pop  = write_grant && e_req;
    @(posedge clk);
    if (resetb) begin
      m_q.delete();
      m_out = 0;
      m_err = 0;
    end else begin
      if (write_grant && !e_req) m_err = 1;
      if (e_pop && !wr_rsp_valid) m_out++;
      else if (!e_pop && wr_rsp_valid) begin
        if (m_out == 0) m_err = 1;
        else            m_out--;
      end
      if (!afu_en) m_q.delete();
      else begin
        if (e_pop)  void'(m_q.pop_front());
        if (e_push) m_q.push_back('{h: in_header, d: in_data});
      end
    end
    @(negedge clk);
    write_grant = 1'b0;
  endtask

  task automatic do_reset();
    resetb = 1'b1; afu_en = 1'b1; in_valid = 1'b0; grant_req = 0; stray = 0; wr_rsp_valid = 1'b0;
    step(); step();
    resetb = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; n_gnt = 0; n_acc = 0;
    m_out = 0; m_err = 0;
    resetb = 1'b1; afu_en = 1'b1; in_valid = 1'b0; write_grant = 1'b0; wr_rsp_valid = 1'b0;
    grant_req = 0; stray = 0;
    in_header = '0; in_data = '0;
    @(negedge clk);
    do_reset();

    // 1: three packets, grant every cycle, heads leave in order
    gnt_log.delete();
    grant_req = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      new_pkt(42'h10 + 42'(k));
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("t1_grants", gnt_log.size(), 3);
    if (gnt_log.size() >= 3)
      for (int k = 0; k < 3; k++) chk("t1_addr", gnt_log[k], 42'h10 + 42'(k));
    chk("t1_out", outstanding, 3);
    chk("t1_idle", idle, 0);

    // 2: fill with no grants, then full + pop still refuses a push
    do_reset();
    n_acc = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      new_pkt(42'h100 + 42'(k));
      step();
    end
    chk("t2_accepted", n_acc, 8);
    grant_req = 1;
    new_pkt(42'h1ff);
    step();
    chk("t2_acc_after_pop", n_acc, 8);
    in_valid = 1'b0; grant_req = 0;

    // 3: outstanding limit stops requests; one response reopens the window
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      new_pkt(42'h200 + 42'(k));
      step();
    end
    in_valid = 1'b0;
    n_gnt = 0; grant_req = 1;
    for (int k = 0; k < 6; k++) step();
    chk("t3_grants_cap", n_gnt, 4);
    chk("t3_req_low", wr_request, 0);
    wr_rsp_valid = 1'b1; step();
    wr_rsp_valid = 1'b0; step();
    chk("t3_fifth", n_gnt, 5);
    grant_req = 0;

    // 4: grant and response together leave the count unchanged
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      new_pkt(42'h300 + 42'(k));
      step();
    end
    in_valid = 1'b0; grant_req = 1;
    step(); step();
    grant_req = 0; step();
    chk("t4_out_pre", outstanding, 2);
    grant_req = 1; wr_rsp_valid = 1'b1; step();
    grant_req = 0; wr_rsp_valid = 1'b0;
    chk("t4_out_post", outstanding, 2);

    // 5: response underflow, then stray grant on an empty FIFO
    do_reset();
    wr_rsp_valid = 1'b1; step();
    wr_rsp_valid = 1'b0;
    chk("t5_err_rsp", error, 1);
    chk("t5_out0", outstanding, 0);
    do_reset();
    stray = 1; step(); stray = 0;
    chk("t5_err_gnt", error, 1);
    in_valid = 1'b1; new_pkt(42'h3a5); step();
    in_valid = 1'b0; step();
    chk("t5_head", wr_header.addr, 42'h3a5);

    // 6: disable flushes queue, late responses still drain
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      new_pkt(42'h400 + 42'(k));
      step();
    end
    in_valid = 1'b0; grant_req = 1;
    for (int k = 0; k < 3; k++) step();
    grant_req = 0;
    chk("t6_out3", outstanding, 3);
    afu_en = 1'b0; step();
    chk("t6_req_off", wr_request, 0);
    wr_rsp_valid = 1'b1;
    for (int k = 0; k < 3; k++) step();
    wr_rsp_valid = 1'b0; afu_en = 1'b1;
    #1;
    chk("t6_empty_req", wr_request, 0);
    chk("t6_out0", outstanding, 0);
    chk("t6_idle", idle, 1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      resetb       = ($urandom_range(0, 63) == 0);
      afu_en       = ($urandom_range(0, 15) != 0);
      in_valid     = $urandom_range(0, 1);
      grant_req    = ($urandom_range(0, 3) != 0);
      stray        = ($urandom_range(0, 99) == 0);
      wr_rsp_valid = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      new_pkt(42'($urandom()));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
